hamming_rx_sequencer: RTL and testbench
=======================================

HAMMING_RX_SEQUENCER -- requirements
Module: hamming_rx_sequencer

Interface
REQ-001 Parameter OVERSAMPLE, default 8: ticks per bit period; power of two, 4..16.
REQ-002 Parameter FRAME_BITS, default 7: data bits per frame, one Hamming(7,4) codeword, range 1..8.
REQ-003 Port clk, input, 1: single clock for all state.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port ena, input, 1: oversample tick; the counter and FSM advance only on cycles with ena=1.
REQ-006 Port rx_in, input, 1: asynchronous serial line; idle high, 8N1-style framing, LSB first.
REQ-007 Port dec_ena, output, 1: one-cycle strobe telling the downstream decoder to shift in dec_bit.
REQ-008 Port dec_bit, output, 1: sampled data bit; valid only while dec_ena=1.
REQ-009 Port bit_idx, output, 3: index of the next data bit to sample (0..FRAME_BITS-1).
REQ-010 Port os_count, output, log2(OVERSAMPLE): current oversample counter, for debug.
REQ-011 Port state, output, 2: FSM state encoding, for debug.
REQ-012 Port frame_done, output, 1: one-cycle pulse on a good stop bit.
REQ-013 Port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-014 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-015 rx_in shall pass through a 2-flop synchronizer (rx_s) that resets to 1; all decisions use rx_s, so added latency is 2 clk cycles.
REQ-016 The FSM shall have states IDLE=0, START=1, DATA=2, STOP=3.
REQ-017 IDLE: on a tick where rx_s=0 and the previous registered rx_s=1 (falling edge), go to START and clear os_count; a line held low shall not retrigger.
REQ-018 os_count shall increment by 1 on each tick in START, DATA and STOP, and wrap from OVERSAMPLE-1 to 0.
REQ-019 START: on a tick with os_count=OVERSAMPLE/2-1 (mid start bit):
  - if rx_s=0, go to DATA and clear os_count and bit_idx;
  - if rx_s=1 (glitch), go back to IDLE with no pulses.
REQ-020 DATA: on a tick with os_count=OVERSAMPLE-1, assert dec_ena for exactly one cycle with dec_bit=rx_s, then increment bit_idx.
REQ-021 DATA: after the sample with bit_idx=FRAME_BITS-1, go to STOP; bit_idx shall not wrap within a frame.
REQ-022 STOP: on a tick with os_count=OVERSAMPLE-1, sample rx_s:
  - 1: pulse frame_done;
  - 0: pulse frame_err.
  In both cases go to IDLE.
REQ-023 Sample points, counted in ticks from the detecting tick: start check at tick OVERSAMPLE/2, data bit k at OVERSAMPLE/2 + (k+1)*OVERSAMPLE, stop bit at OVERSAMPLE/2 + (FRAME_BITS+1)*OVERSAMPLE.
REQ-024 With ena=0, every register except the synchronizer shall hold its value; dec_ena, frame_done and frame_err shall be 0.
REQ-025 dec_ena, frame_done and frame_err shall be registered outputs and mutually exclusive.
REQ-026 After frame_err, a new frame shall start only after rx_s returns to 1 and then falls again, so a break condition is rejected.

Reset
REQ-027 When rst=1:
  - state=IDLE, os_count=0, bit_idx=0;
  - dec_ena=0, dec_bit=0, frame_done=0, frame_err=0, busy=0;
  - synchronizer flops=1.
REQ-028 A reset asserted mid-frame shall abort the frame with no further pulses; after release the block shall wait for a fresh falling edge.

Structure
REQ-029 A shared package shall hold the state encoding constants (IDLE/START/DATA/STOP) and the default OVERSAMPLE and FRAME_BITS values; the package is also used by the decoder top.
REQ-030 One sub-module, rx_sync2, shall implement the reset-to-1 two-flop synchronizer; the counter and FSM stay in this module.

Verification
REQ-031 ena=1, frame start 0, data 1010101 (LSB first), stop 1 -> seven dec_ena pulses with dec_bit 1,0,1,0,1,0,1, bit_idx 0..6, one frame_done, no frame_err; the first dec_ena comes 12 ticks after the edge plus sync latency.
REQ-032 Low glitch of 2 ticks on rx_in in IDLE -> return to IDLE at tick 4, no dec_ena, busy drops after at most 6 cycles.
REQ-033 Valid frame with stop bit 0, line held low for 40 ticks -> frame_err once; no START until rx goes high then low again.
REQ-034 ena toggling 1-of-3 cycles with the frame from REQ-031 stretched to match -> identical bit sequence; no pulse while ena=0.
REQ-035 rst asserted asynchronously after the 3rd dec_ena -> all outputs at reset values immediately; the next full frame decodes correctly.
REQ-036 Two back-to-back frames (stop bit followed directly by start bit) -> 14 dec_ena and 2 frame_done, bit_idx restarts at 0.

Source files
------------

// File: rtl/hamming_rx_sequencer_pkg.sv
// Shared definitions for the Hamming(7,4) serial receive path: FSM encoding
// and default framing parameters, also used by the decoder top.
package hamming_rx_sequencer_pkg;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int FRAME_BITS_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchronizer for an idle-high serial line; both flops reset to 1
// so reset never looks like a start-bit edge.
module rx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hamming_rx_sequencer.sv
// Oversampled serial receiver front end: finds the start bit, samples one
// codeword bit per bit period into the decoder and checks the stop bit.
module hamming_rx_sequencer
  import hamming_rx_sequencer_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          rx_in,
  output logic                          dec_ena,
  output logic                          dec_bit,
  output logic [2:0]                    bit_idx,
  output logic [$clog2(OVERSAMPLE)-1:0] os_count,
  output logic [1:0]                    state,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_MID   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST  = OSW'(OVERSAMPLE - 1);
  localparam logic [2:0]     IDX_LAST = 3'(FRAME_BITS - 1);

  rx_state_t      state_q, state_nxt;
  logic           rx_s, rx_prev;
  logic           fall, mid, last;
  logic [OSW-1:0] os_nxt;
  logic [2:0]     idx_nxt;
  logic           dec_ena_nxt, dec_bit_nxt, done_nxt, err_nxt;

  rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // rx_prev only follows rx_s on ticks, so a line held low after a bad
  // stop bit cannot look like a new falling edge.
  assign fall  = rx_prev & ~rx_s;
  assign mid   = (os_count == OS_MID);
  assign last  = (os_count == OS_LAST);
  assign busy  = (state_q != ST_IDLE);
  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    if (ena) begin
      unique case (state_q)
        ST_IDLE:  if (fall) state_nxt = ST_START;
        ST_START: if (mid) state_nxt = rx_s ? ST_IDLE : ST_DATA;
        ST_DATA:  if (last && bit_idx == IDX_LAST) state_nxt = ST_STOP;
        ST_STOP:  if (last) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    os_nxt      = os_count;
    idx_nxt     = bit_idx;
    dec_ena_nxt = 1'b0;
    dec_bit_nxt = dec_bit;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    if (ena) begin
      unique case (state_q)
        ST_IDLE: os_nxt = '0;
        ST_START: begin
          if (mid) begin
            os_nxt  = '0;
            idx_nxt = '0;
          end else begin
            os_nxt = os_count + OSW'(1);
          end
        end
        ST_DATA: begin
          os_nxt = os_count + OSW'(1);
          if (last) begin
            dec_ena_nxt = 1'b1;
            dec_bit_nxt = rx_s;
            if (bit_idx != IDX_LAST) idx_nxt = bit_idx + 3'd1;
          end
        end
        ST_STOP: begin
          os_nxt = os_count + OSW'(1);
          if (last) begin
            done_nxt = rx_s;
            err_nxt  = ~rx_s;
          end
        end
        default: os_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev    <= 1'b1;
      os_count   <= '0;
      bit_idx    <= '0;
      dec_ena    <= 1'b0;
      dec_bit    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (ena) rx_prev <= rx_s;
      os_count   <= os_nxt;
      bit_idx    <= idx_nxt;
      dec_ena    <= dec_ena_nxt;
      dec_bit    <= dec_bit_nxt;
      frame_done <= done_nxt;
      frame_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_hamming_rx_sequencer.sv
// Directed bench for hamming_rx_sequencer: framed codewords, glitches,
// break condition, sparse ticks, mid-frame reset and back-to-back frames.
module tb_hamming_rx_sequencer;

  localparam int OS = 8;
  localparam int FB = 7;

  logic       clk = 1'b0;
  logic       rst, ena, rx_in;
  logic       dec_ena, dec_bit, frame_done, frame_err, busy;
  logic [2:0] bit_idx;
  logic [2:0] os_count;
  logic [1:0] state;

  always #5 clk = ~clk;

  hamming_rx_sequencer #(.OVERSAMPLE(OS), .FRAME_BITS(FB)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .rx_in      (rx_in),
    .dec_ena    (dec_ena),
    .dec_bit    (dec_bit),
    .bit_idx    (bit_idx),
    .os_count   (os_count),
    .state      (state),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: logs every pulse with the bit index that was current at the
  // sampling tick, and counts busy cycles, frame starts and rule breaks.
  int   n_dec = 0, n_done = 0, n_err = 0, n_start = 0, n_busy = 0;
  int   excl_viol = 0, ena_viol = 0;
  logic bits_q [64];
  int   idx_q  [64];
  int   dcyc   [64];
  logic [2:0] prev_idx = 3'd0;
  logic prev_ena = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dec_ena) begin
        if (n_dec < 64) begin
          bits_q[n_dec] <= dec_bit;
          idx_q[n_dec]  <= int'(prev_idx);
          dcyc[n_dec]   <= cyc;
        end
        n_dec <= n_dec + 1;
      end
      if (frame_done) n_done <= n_done + 1;
      if (frame_err)  n_err  <= n_err + 1;
      if ((dec_ena || frame_done || frame_err) && !prev_ena) ena_viol <= ena_viol + 1;
      if (int'(dec_ena) + int'(frame_done) + int'(frame_err) > 1) excl_viol <= excl_viol + 1;
      if (busy) n_busy <= n_busy + 1;
      if (busy && !prev_busy) n_start <= n_start + 1;
    end
    prev_idx  <= bit_idx;
    prev_ena  <= ena;
    prev_busy <= busy;
  end

  int checks = 0, errors = 0;
  int div = 1;
  int last_fall = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < div; i++) begin
      ena = (i == 0);
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (OS) tick();
  endtask

  task automatic send_frame(input logic [6:0] d, input logic stp);
    last_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < FB; i++) send_bit(d[i]);
    send_bit(stp);
  endtask

  task automatic idle(input int nt);
    rx_in = 1'b1;
    repeat (nt) tick();
  endtask

  task automatic check_frame(input string tag, input int bn, input logic [6:0] d);
    for (int i = 0; i < FB; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), int'(bits_q[bn + i]), int'(d[i]));
      chk($sformatf("%s_idx%0d", tag, i), idx_q[bn + i], i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_os"}, int'(os_count), 0);
    chk({tag, "_idx"}, int'(bit_idx), 0);
    chk({tag, "_dec_ena"}, int'(dec_ena), 0);
    chk({tag, "_dec_bit"}, int'(dec_bit), 0);
    chk({tag, "_done"}, int'(frame_done), 0);
    chk({tag, "_err"}, int'(frame_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  int bn, bd, be, bs, bb;
  logic [6:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;

  initial begin
    pat_a = 7'b1010101;
    pat_b = 7'b0110011;
    pat_c = 7'b1100101;
    pat_d = 7'b0101100;
    pat_e = 7'b1001110;
    pat_f = 7'b0011011;
    rst = 1'b1; ena = 1'b0; rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("por");
    rst = 1'b0;
    idle(4);

    // Basic frame, ena every cycle
    bn = n_dec; bd = n_done; be = n_err;
    send_frame(pat_a, 1'b1);
    idle(OS);
    chk("f1_ndec", n_dec - bn, 7);
    check_frame("f1", bn, pat_a);
    chk("f1_done", n_done - bd, 1);
    chk("f1_err", n_err - be, 0);
    chk("f1_latency", dcyc[bn] - last_fall, 15);
    chk("f1_spacing", dcyc[bn + 1] - dcyc[bn], 8);

    // Two-tick low glitch
    bn = n_dec; bd = n_done; be = n_err; bs = n_start; bb = n_busy;
    rx_in = 1'b0;
    tick(); tick();
    idle(2 * OS);
    chk("gl_busy_cycles", n_busy - bb, 4);
    chk("gl_starts", n_start - bs, 1);
    chk("gl_ndec", n_dec - bn, 0);
    chk("gl_pulses", (n_done - bd) + (n_err - be), 0);
    chk("gl_state", int'(state), 0);

    // Bad stop bit followed by a long break
    bn = n_dec; bd = n_done; be = n_err; bs = n_start;
    send_frame(pat_b, 1'b0);
    repeat (40) tick();
    chk("br_ndec", n_dec - bn, 7);
    check_frame("br", bn, pat_b);
    chk("br_err", n_err - be, 1);
    chk("br_done", n_done - bd, 0);
    chk("br_starts", n_start - bs, 1);
    chk("br_state", int'(state), 0);
    idle(2 * OS);
    bn = n_dec; bd = n_done;
    send_frame(pat_c, 1'b1);
    idle(OS);
    chk("ab_ndec", n_dec - bn, 7);
    check_frame("ab", bn, pat_c);
    chk("ab_done", n_done - bd, 1);

    // Tick on one cycle of three
    div = 3;
    bn = n_dec; bd = n_done; be = n_err;
    send_frame(pat_a, 1'b1);
    idle(OS);
    div = 1;
    chk("sp_ndec", n_dec - bn, 7);
    check_frame("sp", bn, pat_a);
    chk("sp_done", n_done - bd, 1);
    chk("sp_err", n_err - be, 0);

    // Asynchronous reset after the third data pulse
    bn = n_dec; bd = n_done; be = n_err;
    last_fall = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(pat_a[i]);
    for (int i = 0; i < 20 && (n_dec - bn) < 3; i++) @(negedge clk);
    chk("rs_pre_ndec", n_dec - bn, 4);
    @(negedge clk);
    #1;
    rst = 1'b1;
    rx_in = 1'b1;
    #1;
    check_reset_outputs("mid");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2 * OS);
    chk("rs_quiet_ndec", n_dec - bn, 4);
    chk("rs_quiet_pulses", (n_done - bd) + (n_err - be), 0);
    bn = n_dec; bd = n_done;
    send_frame(pat_d, 1'b1);
    idle(OS);
    chk("rs_ndec", n_dec - bn, 7);
    check_frame("rs", bn, pat_d);
    chk("rs_done", n_done - bd, 1);

    // Back-to-back frames
    bn = n_dec; bd = n_done; be = n_err;
    send_frame(pat_e, 1'b1);
    send_frame(pat_f, 1'b1);
    idle(OS);
    chk("bb_ndec", n_dec - bn, 14);
    check_frame("bb0", bn, pat_e);
    check_frame("bb1", bn + 7, pat_f);
    chk("bb_done", n_done - bd, 2);
    chk("bb_err", n_err - be, 0);

    chk("pulse_exclusive", excl_viol, 0);
    chk("pulse_after_tick", ena_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
